// File: rtl/led_pwm_bank_pkg.sv
// Shared types and defaults for the LED PWM bank.
package led_pwm_bank_pkg;

  // Channel operating modes, encoded as they appear on cfg_mode.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned PRESC_W_DEF = 30;

endpackage

// File: rtl/led_pwm_bank_tick_gen.sv
// Prescaler: emits a one-clk tick every (prescale+1) clocks.
module tick_gen
  import led_pwm_bank_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] count_q, count_d;
  // Low for the first cycle out of reset so tick stays quiet there even at prescale 0.
  logic               armed_q;

  // A count at or above prescale (terminal value, or prescale shrank) restarts at 0.
  // NOTE: combinational blocks give every output a value on every path, so no latch is inferred.
  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q >= prescale) count_d = '0;
  end

  // An overshot count (prescale lowered below it) never compares equal, so it reloads silently.
  assign tick = armed_q && (count_q == prescale);

  // Prescaler count register.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of LED channels sharing one prescaler and one PWM phase counter.
// Each channel runs OFF/ON/PWM/BREATHE; new settings take effect only at the
// phase wrap so an output never sees a shortened pulse.
module led_pwm_bank
  import led_pwm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_duty,
  output logic               tick,
  output logic               period_end,
  output logic [NUM_CH-1:0]  led
);

  logic [CNT_W-1:0] phase_q, phase_d;

  tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale),
    .tick     (tick)
  );

  assign period_end = tick && (phase_q == {CNT_W{1'b1}});

  // Shared phase advances one step per tick and wraps naturally.
  always_comb begin
    phase_d = phase_q;
    if (tick) phase_d = phase_q + 1'b1;
  end

  // Shared phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
    logic [CNT_W-1:0] pend_duty_q, pend_duty_d, act_duty_q, act_duty_d;
    logic [CNT_W-1:0] ramp_q, ramp_d;
    logic             up_q, up_d, led_q, led_d;
    logic             wr;

    // Channel indices with no channel behind them never match, so those writes drop.
    assign wr = cfg_we && (cfg_ch == 4'(i));

    // Pending capture, period-boundary activation, breathe ramp and LED drive.
    always_comb begin
      pend_mode_d = pend_mode_q;
      pend_duty_d = pend_duty_q;
      act_mode_d  = act_mode_q;
      act_duty_d  = act_duty_q;
      ramp_d      = ramp_q;
      up_d        = up_q;
      led_d       = 1'b0;

      if (wr) begin
        pend_mode_d = mode_e'(cfg_mode);
        pend_duty_d = cfg_duty;
      end

      // Activation sees this cycle's write, so a write on the wrap cycle applies at once.
      if (period_end) begin
        act_mode_d = pend_mode_d;
        act_duty_d = pend_duty_d;
        if (pend_mode_d != MODE_BREATHE || act_mode_q != MODE_BREATHE
            || pend_duty_d == '0) begin
          ramp_d = '0;
          up_d   = 1'b1;
        end else if (ramp_q > pend_duty_d) begin
          ramp_d = pend_duty_d;
          up_d   = 1'b0;
        end else if (up_q ? (ramp_q < pend_duty_d) : (ramp_q == '0)) begin
          ramp_d = ramp_q + 1'b1;
          up_d   = (ramp_d != pend_duty_d);
        end else begin
          ramp_d = ramp_q - 1'b1;
          up_d   = (ramp_q == {{(CNT_W-1){1'b0}}, 1'b1});
        end
      end

      unique case (act_mode_q)
        MODE_OFF:     led_d = 1'b0;
        MODE_ON:      led_d = 1'b1;
        MODE_PWM:     led_d = (phase_q < act_duty_q);
        MODE_BREATHE: led_d = (phase_q < ramp_q);
        default:      led_d = 1'b0;
      endcase
    end

    // Per-channel configuration, ramp and LED registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pend_mode_q <= MODE_OFF;
        pend_duty_q <= '0;
        act_mode_q  <= MODE_OFF;
        act_duty_q  <= '0;
        ramp_q      <= '0;
        up_q        <= 1'b1;
        led_q       <= 1'b0;
      end else begin
        pend_mode_q <= pend_mode_d;
        pend_duty_q <= pend_duty_d;
        act_mode_q  <= act_mode_d;
        act_duty_q  <= act_duty_d;
        ramp_q      <= ramp_d;
        up_q        <= up_d;
        led_q       <= led_d;
      end
    end

    assign led[i] = led_q;
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank: directed scenarios plus random
// configuration traffic, all compared cycle by cycle against a reference model.
module tb_led_pwm_bank;
  import led_pwm_bank_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 30;
  localparam int PHASES  = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PRESC_W-1:0] prescale;
  logic               cfg_we;
  logic [3:0]         cfg_ch;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_duty;
  logic               tick, period_end;
  logic [NUM_CH-1:0]  led;

  always #5 clk = ~clk;

  led_pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prescale   (prescale),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_duty   (cfg_duty),
    .tick       (tick),
    .period_end (period_end),
    .led        (led)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed clocks within the tick period, position in the
  // LED period, settings per channel and a triangular ramp per channel.
  int               m_elapsed;
  bit               m_live;
  int               m_pos;
  int               pm [NUM_CH], pd [NUM_CH], am [NUM_CH], ad [NUM_CH], rr [NUM_CH];
  bit               rup [NUM_CH];
  bit [NUM_CH-1:0]  m_led;
  int               win_hi [NUM_CH];

  function automatic bit lit(input int mode, input int duty, input int r, input int pos);
    if (mode == int'(MODE_ON))      return 1'b1;
    if (mode == int'(MODE_PWM))     return pos < duty;
    if (mode == int'(MODE_BREATHE)) return pos < r;
    return 1'b0;
  endfunction

  function automatic bit exp_tick();
    return m_live && (m_elapsed == int'(prescale));
  endfunction

  function automatic bit exp_pe();
    return exp_tick() && (m_pos == PHASES - 1);
  endfunction

  // Walk the ramp one step along the triangle 0..peak..0.
  task automatic ramp_walk(input int i, input int peak);
    if (peak == 0) begin
      rr[i] = 0; rup[i] = 1'b1;
    end else if (rr[i] > peak) begin
      rr[i] = peak; rup[i] = 1'b0;
    end else begin
      if (rr[i] == peak) rup[i] = 1'b0;
      if (rr[i] == 0)    rup[i] = 1'b1;
      rr[i] = rup[i] ? rr[i] + 1 : rr[i] - 1;
      if (rr[i] == peak) rup[i] = 1'b0;
      if (rr[i] == 0)    rup[i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit t, pe;
    if (!rst_n) begin
      m_elapsed = 0; m_live = 1'b0; m_pos = 0; m_led = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pm[i] = 0; pd[i] = 0; am[i] = 0; ad[i] = 0; rr[i] = 0; rup[i] = 1'b1;
      end
    end else begin
      t  = exp_tick();
      pe = exp_pe();
      for (int i = 0; i < NUM_CH; i++) m_led[i] = lit(am[i], ad[i], rr[i], m_pos);
      if (cfg_we && int'(cfg_ch) < NUM_CH) begin
        pm[cfg_ch] = int'(cfg_mode);
        pd[cfg_ch] = int'(cfg_duty);
      end
      if (pe) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pm[i] == int'(MODE_BREATHE) && am[i] == int'(MODE_BREATHE)) ramp_walk(i, pd[i]);
          else begin rr[i] = 0; rup[i] = 1'b1; end
          am[i] = pm[i];
          ad[i] = pd[i];
        end
      end
      m_elapsed = (m_elapsed >= int'(prescale)) ? 0 : m_elapsed + 1;
      m_live = 1'b1;
      if (t) m_pos = (m_pos + 1) % PHASES;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tick", tick, exp_tick());
    check("period_end", period_end, exp_pe());
    check("led", led, m_led);
  endtask

  task automatic wait_pe(input int budget);
    int k = 0;
    while (period_end !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check("period_end_reached", period_end, 1'b1);
  endtask

  // One LED period of samples, optionally writing a channel at sample wr_at.
  task automatic window(input int wr_at, input int wch, input int wmode, input int wduty);
    for (int i = 0; i < NUM_CH; i++) win_hi[i] = 0;
    for (int j = 1; j <= PHASES; j++) begin
      if (j == wr_at) begin
        cfg_we = 1'b1; cfg_ch = 4'(wch); cfg_mode = 2'(wmode); cfg_duty = 8'(wduty);
      end
      step();
      cfg_we = 1'b0;
      for (int i = 0; i < NUM_CH; i++) win_hi[i] += int'(led[i]);
    end
  endtask

  int nt;
  int breathe_exp [7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    rst_n = 1'b0; prescale = 3; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0;
    // Writes during reset must be dropped.
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_mode = 2'd1;
    step();
    step();
    cfg_we = 1'b0;
    check("reset_led", led, 0);
    check("reset_tick", tick, 0);
    rst_n = 1'b1;

    // Tick every 4th clock at prescale 3.
    nt = 0;
    repeat (16) begin step(); nt += int'(tick); end
    check("tick_every_4", nt, 4);

    // Shrink prescale while the count sits at 3.
    nt = 0;
    while (tick !== 1'b1 && nt < 8) begin step(); nt++; end
    check("tick_seen", tick, 1'b1);
    prescale = 1;
    #1;
    check("no_tick_after_shrink", tick, 1'b0);
    step();
    check("reload_no_tick", tick, 1'b0);
    nt = 0;
    repeat (8) begin step(); nt += int'(tick); end
    check("tick_every_2", nt, 4);

    // PWM at full rate; mid-period duty change on ch1.
    prescale = 0;
    window(1, 0, int'(MODE_PWM), 64);
    window(1, 1, int'(MODE_PWM), 32);
    wait_pe(2 * PHASES);
    window(-1, 0, 0, 0);
    check("ch0_duty64", win_hi[0], 64);
    check("ch1_duty32", win_hi[1], 32);
    window(100, 1, int'(MODE_PWM), 200);
    check("ch1_keeps_32", win_hi[1], 32);
    window(-1, 0, 0, 0);
    check("ch1_duty200", win_hi[1], 200);
    check("ch0_still_64", win_hi[0], 64);

    // Breathe on ch2, written on the period_end cycle itself.
    window(1, 2, int'(MODE_BREATHE), 3);
    check("breathe_p0", win_hi[2], 0);
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      window(1, 3, int'(MODE_ON), 0);
      else if (k == 1) window(50, 7, int'(MODE_ON), 255);
      else             window(-1, 0, 0, 0);
      check($sformatf("breathe_p%0d", k + 1), win_hi[2], breathe_exp[k]);
      if (k == 0) check("ch3_on_same_cycle", win_hi[3], 255);
      check("ch0_unaffected", win_hi[0], 64);
    end

    // One-clock reset in the middle of a breathe period.
    repeat (50) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_led", led, 0);
    check("rst_mid_tick", tick, 0);
    nt = 0;
    repeat (300) begin step(); nt += int'(led != '0); end
    check("all_off_after_reset", nt, 0);
    wait_pe(2 * PHASES);
    window(1, 2, int'(MODE_BREATHE), 3);
    check("ramp_restart_0", win_hi[2], 0);
    window(-1, 0, 0, 0);
    check("ramp_restart_1", win_hi[2], 1);

    // Random traffic, including out-of-range channels and prescale changes.
    repeat (5000) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we   = 1'b1;
        cfg_ch   = 4'($urandom_range(0, 7));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_duty = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      end
      if ($urandom_range(0, 1499) == 0) prescale = PRESC_W'($urandom_range(0, 2));
      if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
      step();
      cfg_we = 1'b0;
      rst_n  = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: PWM phase/duty width.
REQ-003 SHALL have parameter PRESC_W, default 30: prescaler width.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port prescale  input  PRESC_W: tick period minus one, in clk cycles.
REQ-007 SHALL have port cfg_we  input  1: one-cycle configuration write strobe.
REQ-008 SHALL have port cfg_ch  input  4: target channel index.
REQ-009 SHALL have port cfg_mode  input  2: channel mode (OFF=0, ON=1, PWM=2, BREATHE=3).
REQ-010 SHALL have port cfg_duty  input  CNT_W: duty (PWM) or peak duty (BREATHE).
REQ-011 SHALL have port tick  output  1: one-clk pulse per prescaler period.
REQ-012 SHALL have port period_end  output  1: one-clk pulse on the tick where phase wraps.
REQ-013 SHALL have port led  output  NUM_CH: registered LED drives.

Function
REQ-014 Prescaler SHALL count 0..prescale; tick=1 for the cycle in which count==prescale, and count SHALL return to 0 in the next cycle.
REQ-015 prescale=0 SHALL give tick=1 on every cycle.
REQ-016 If count>prescale after a prescale change, count SHALL reload 0 on the next cycle without asserting tick.
REQ-017 Shared phase counter (CNT_W bits) SHALL increment on each tick, wrapping 2^CNT_W-1 -> 0.
REQ-018 period_end SHALL equal tick AND phase==2^CNT_W-1.
REQ-019 cfg_we with cfg_ch<NUM_CH SHALL load pending mode/duty for that channel; cfg_ch>=NUM_CH SHALL be ignored.
REQ-020 Active mode/duty SHALL load from pending only on period_end (glitch-free update).
REQ-021 cfg_we coincident with period_end SHALL land in pending, and the newly written value SHALL become active in that same cycle.
REQ-022 OFF SHALL drive led[i]=0; ON SHALL drive led[i]=1.
REQ-023 PWM SHALL drive led[i]=(phase<active_duty); duty 0 is always off, duty 2^CNT_W-1 is off for one phase step per period.
REQ-024 BREATHE SHALL keep per-channel ramp duty r and direction bit d; on each period_end, r increments while d=up and decrements while d=down.
REQ-025 BREATHE SHALL set d=down when r reaches active_duty and d=up when r reaches 0; led[i]=(phase<r).
REQ-026 Entering BREATHE from another mode SHALL start with r=0, d=up; active_duty 0 SHALL hold r=0.
REQ-027 If active_duty drops below r, r SHALL clamp to active_duty at the next period_end and d SHALL be set to down.
REQ-028 led SHALL update exactly one clk after the phase/active/ramp state it reflects.

Reset
REQ-029 With rst_n=0 at a clk edge: prescaler, phase, and all ramps SHALL be 0; all d SHALL be up.
REQ-030 With rst_n=0 at a clk edge: pending and active modes SHALL be OFF and duties 0.
REQ-031 With rst_n=0 at a clk edge: tick, period_end, and led SHALL be 0.
REQ-032 Reset asserted mid-period SHALL take effect at that edge; cfg_we during reset SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the mode enumeration (OFF/ON/PWM/BREATHE) and the CNT_W/PRESC_W defaults.
REQ-034 The prescaler SHALL be a separate sub-module tick_gen (clk, rst_n, prescale -> tick).
REQ-035 Per-channel logic SHALL be a generate loop.

Verification
REQ-036 Bench SHALL cover: prescale=3 -> tick every 4th clk; change to 1 while count=3 -> count 0 next cycle, no tick that cycle, then tick every 2nd clk.
REQ-037 Bench SHALL cover: prescale=0, ch0 PWM duty=64, CNT_W=8 -> led[0] high 64 of every 256 cycles, starting after the first period_end.
REQ-038 Bench SHALL cover: mid-period write ch1 duty 32->200 -> led[1] keeps 32-duty until period_end, then 200 (no runt pulse).
REQ-039 Bench SHALL cover: ch2 BREATHE peak=3 -> per-period high counts 0,1,2,3,2,1,0,1...
REQ-040 Bench SHALL cover: cfg_ch=7 with NUM_CH=4 -> no state change; cfg_we on period_end cycle -> value active in the same cycle.
REQ-041 Bench SHALL cover: rst_n low for 1 clk mid-BREATHE -> next cycle led=0, tick=0, ramp=0, all modes OFF.
